// File: rtl/fetch_unit.sv
// LC-3b instruction fetch front end: PC register, imem read/resp handshake,
// PC-mux redirect, and an output register plus one-entry skid toward decode.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [1:0]  pcmux_sel,
    input  logic [15:0] br_target,
    input  logic [15:0] trap_target,
    input  logic [15:0] jmp_target,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc,
    output logic [15:0] if_npc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_pc;
    logic [15:0] w_pc_next;

    logic        r_out_valid;
    logic [15:0] r_out_ir;
    logic [15:0] r_out_pc;
    logic [15:0] r_out_npc;
    logic        w_out_valid_next;
    logic [15:0] w_out_ir_next;
    logic [15:0] w_out_pc_next;
    logic [15:0] w_out_npc_next;

    logic        r_skid_valid;
    logic [15:0] r_skid_ir;
    logic [15:0] r_skid_pc;
    logic        w_skid_valid_next;
    logic [15:0] w_skid_ir_next;
    logic [15:0] w_skid_pc_next;

    logic [15:0] w_target_raw;
    logic [15:0] w_target;
    logic [15:0] w_pc_inc;
    logic        w_redirect;
    logic        w_req_active;
    logic        w_consume;

    always_comb begin
        case (pcmux_sel)
            2'b01:   w_target_raw = br_target;
            2'b10:   w_target_raw = trap_target;
            2'b11:   w_target_raw = jmp_target;
            default: w_target_raw = r_pc;
        endcase
    end

    // Instruction addresses are word aligned, so the low bit is dropped.
    assign w_target     = {w_target_raw[15:1], 1'b0};
    assign w_redirect   = redirect_valid && (pcmux_sel != 2'b00);
    assign w_req_active = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign w_consume    = r_out_valid && id_ready;
    assign w_pc_inc     = r_pc + 16'd2;

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_out_valid_next  = r_out_valid;
        w_out_ir_next     = r_out_ir;
        w_out_pc_next     = r_out_pc;
        w_out_npc_next    = r_out_npc;
        w_skid_valid_next = r_skid_valid;
        w_skid_ir_next    = r_skid_ir;
        w_skid_pc_next    = r_skid_pc;

        if (w_redirect) begin
            // A redirect kills both buffers even if decode is taking the head.
            w_pc_next         = w_target;
            w_out_valid_next  = 1'b0;
            w_skid_valid_next = 1'b0;
            w_state_next      = (w_req_active && !imem_resp) ? S_DISCARD : S_FETCH;
        end else begin
            if (w_consume) begin
                w_out_valid_next  = r_skid_valid;
                w_out_ir_next     = r_skid_ir;
                w_out_pc_next     = r_skid_pc;
                w_out_npc_next    = r_skid_pc + 16'd2;
                w_skid_valid_next = 1'b0;
            end

            case (r_state)
                S_FETCH: begin
                    if (imem_resp) begin
                        if ((!r_out_valid || w_consume) && !r_skid_valid) begin
                            w_out_valid_next = 1'b1;
                            w_out_ir_next    = imem_rdata;
                            w_out_pc_next    = r_pc;
                            w_out_npc_next   = w_pc_inc;
                        end else begin
                            w_skid_valid_next = 1'b1;
                            w_skid_ir_next    = imem_rdata;
                            w_skid_pc_next    = r_pc;
                        end
                        w_pc_next    = w_pc_inc;
                        w_state_next = w_skid_valid_next ? S_WAIT : S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (!w_skid_valid_next) begin
                        w_state_next = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    // This response completes the request issued before the redirect.
                    if (imem_resp) begin
                        w_state_next = S_FETCH;
                    end
                end
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_out_valid  <= 1'b0;
            r_out_ir     <= 16'h0000;
            r_out_pc     <= 16'h0000;
            r_out_npc    <= 16'h0000;
            r_skid_valid <= 1'b0;
            r_skid_ir    <= 16'h0000;
            r_skid_pc    <= 16'h0000;
        end else begin
            r_pc         <= w_pc_next;
            r_out_valid  <= w_out_valid_next;
            r_out_ir     <= w_out_ir_next;
            r_out_pc     <= w_out_pc_next;
            r_out_npc    <= w_out_npc_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_ir    <= w_skid_ir_next;
            r_skid_pc    <= w_skid_pc_next;
        end
    end

    assign imem_read    = w_req_active && !rst;
    assign imem_address = r_pc;
    assign if_valid     = r_out_valid;
    assign if_ir        = r_out_ir;
    assign if_pc        = r_out_pc;
    assign if_npc       = r_out_npc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency memory model, directed scenarios,
// then random traffic checked against an in-order program-stream scoreboard.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [1:0]  pcmux_sel = 2'b00;
    logic [15:0] br_target = 16'h0000;
    logic [15:0] trap_target = 16'h0000;
    logic [15:0] jmp_target = 16'h0000;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;
    logic [15:0] if_npc;
    logic        id_ready = 1'b0;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .pcmux_sel      (pcmux_sel),
        .br_target      (br_target),
        .trap_target    (trap_target),
        .jmp_target     (jmp_target),
        .imem_read      (imem_read),
        .imem_address   (imem_address),
        .imem_resp      (imem_resp),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_npc         (if_npc),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [15:0] mem [0:32767];
    logic [15:0] tail_pc = RESET_PC;
    int          checks = 0;
    int          errors = 0;
    int          accepts = 0;

    bit          mem_busy = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    int          mem_lat = 0;
    int          force_lat = -1;

    bit          prev_valid = 1'b0;
    bit          prev_rst = 1'b0;
    bit          prev_redir = 1'b0;
    bit          prev_resp = 1'b0;
    logic [15:0] prev_target = 16'h0000;
    logic [15:0] prev_addr = 16'h0000;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, {15'b0, act}, {15'b0, exp});
    endtask

    // Program-order model: after a redirect to T, decode must see T, T+2, ...
    task automatic extend_stream();
        exp_q.push_back({tail_pc, mem[tail_pc[15:1]]});
        tail_pc = tail_pc + 16'd2;
    endtask

    task automatic restart_stream(input logic [15:0] start);
        exp_q.delete();
        tail_pc = start;
        extend_stream();
    endtask

    task automatic post_edge_checks();
        if (prev_valid) begin
            if (prev_rst) begin
                chkb("reset_if_valid", if_valid, 1'b0);
                chk("reset_if_ir", if_ir, 16'h0000);
                chk("reset_if_pc", if_pc, 16'h0000);
                chk("reset_if_npc", if_npc, 16'h0000);
                chk("reset_pc", imem_address, RESET_PC);
            end else if (prev_redir) begin
                chk("redirect_addr", imem_address, prev_target);
                chkb("redirect_if_valid", if_valid, 1'b0);
            end else if (!prev_resp) begin
                chk("pc_hold", imem_address, prev_addr);
            end
        end
    endtask

    task automatic mem_step(input bit eff, input logic [15:0] tgt);
        if (rst) begin
            chkb("read_in_reset", imem_read, 1'b0);
            mem_busy   = 1'b0;
            imem_resp  = 1'b0;
            imem_rdata = 16'($urandom);
        end else begin
            if (!mem_busy && imem_read) begin
                mem_busy = 1'b1;
                mem_addr = imem_address;
                mem_lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end
            if (mem_busy && mem_lat == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = mem[mem_addr[15:1]];
                mem_busy   = 1'b0;
            end else begin
                imem_resp  = 1'b0;
                imem_rdata = 16'($urandom);
                if (mem_busy) mem_lat--;
            end
        end
        prev_valid  = 1'b1;
        prev_rst    = rst;
        prev_redir  = eff;
        prev_target = tgt;
        prev_resp   = imem_resp;
        prev_addr   = imem_address;
    endtask

    // One clock cycle: check the edge's result, drive inputs, then run memory.
    task automatic cyc(input bit r, input bit rv, input logic [1:0] sel,
                       input logic [15:0] tgt, input bit rdy);
        logic [15:0] aligned;
        bit          eff;
        @(posedge clk);
        #1;
        post_edge_checks();
        aligned        = {tgt[15:1], 1'b0};
        eff            = rv && (sel != 2'b00) && !r;
        rst            = r;
        redirect_valid = rv;
        pcmux_sel      = sel;
        br_target      = 16'($urandom);
        trap_target    = 16'($urandom);
        jmp_target     = 16'($urandom);
        case (sel)
            2'b01:   br_target = tgt;
            2'b10:   trap_target = tgt;
            2'b11:   jmp_target = tgt;
            default: ;
        endcase
        id_ready = rdy;
        if (r) restart_stream(RESET_PC);
        else if (eff) restart_stream(aligned);
        #1;
        mem_step(eff, aligned);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 2'b00, 16'h0000, 1'b0);
    endtask

    // Scoreboard monitor: an instruction retires at the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst == 1'b0 && if_valid === 1'b1 && id_ready
                && !(redirect_valid && pcmux_sel != 2'b00)) begin
                if (exp_q.size() == 0) extend_stream();
                mon_e = exp_q.pop_front();
                chk("sb_if_pc", if_pc, mon_e.pc);
                chk("sb_if_ir", if_ir, mon_e.ir);
                chk("sb_if_npc", if_npc, mon_e.pc + 16'd2);
                accepts++;
                $display("accept pc=%h ir=%h npc=%h", if_pc, if_ir, if_npc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] words [0:2];
    bit          r_r;
    bit          r_rv;
    logic [1:0]  r_sel;
    logic [15:0] r_tgt;
    bit          r_rdy;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        words[2] = 16'h9ABC;
        mem[0] = words[0];
        mem[1] = words[1];
        mem[2] = words[2];

        // Back-to-back sequential fetch from reset.
        force_lat = 0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
            chkb("seq_read", imem_read, 1'b1);
            chk("seq_addr", imem_address, 16'(2 * k));
            if (k > 0) begin
                chkb("seq_valid", if_valid, 1'b1);
                chk("seq_pc", if_pc, 16'(2 * (k - 1)));
                chk("seq_ir", if_ir, words[k - 1]);
                chk("seq_npc", if_npc, 16'(2 * k));
            end
        end

        // Decode stall: second word goes to the skid and fetch stops.
        do_reset();
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        chkb("stall_read", imem_read, 1'b0);
        chk("stall_pc", if_pc, 16'h0000);
        chk("stall_ir", if_ir, 16'h1234);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chkb("stall_read2", imem_read, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chkb("drain_valid", if_valid, 1'b1);
        chk("drain_pc", if_pc, 16'h0002);
        chk("drain_ir", if_ir, 16'h5678);
        chkb("resume_read", imem_read, 1'b1);
        chk("resume_addr", imem_address, 16'h0004);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);

        // Branch redirect while idle in the stalled state.
        do_reset();
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b0);
        chkb("br_idle_read", imem_read, 1'b0);
        cyc(1'b0, 1'b1, 2'b01, 16'h3001, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("br_addr", imem_address, 16'h3000);
        chkb("br_valid", if_valid, 1'b0);
        chkb("br_read", imem_read, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("br_first_pc", if_pc, 16'h3000);

        // Trap redirect one cycle before the outstanding response.
        force_lat = 2;
        do_reset();
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        cyc(1'b0, 1'b1, 2'b10, 16'h0400, 1'b1);
        force_lat = 0;
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("trap_addr", imem_address, 16'h0400);
        chkb("trap_read", imem_read, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chkb("trap_drop_valid", if_valid, 1'b0);
        chk("trap_addr2", imem_address, 16'h0400);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chkb("trap_first_valid", if_valid, 1'b1);
        chk("trap_first_pc", if_pc, 16'h0400);

        // Jmp redirect in the same cycle as a response.
        force_lat = 1;
        do_reset();
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        force_lat = 0;
        cyc(1'b0, 1'b1, 2'b11, 16'h2000, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chkb("jmp_read", imem_read, 1'b1);
        chk("jmp_addr", imem_address, 16'h2000);
        chkb("jmp_valid", if_valid, 1'b0);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("jmp_first_pc", if_pc, 16'h2000);

        // PC wrap at 0xFFFE, and redirect_valid with sel 00 as a no-op.
        cyc(1'b0, 1'b1, 2'b11, 16'hFFFF, 1'b1);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("wrap_start", imem_address, 16'hFFFE);
        chkb("wrap_start_valid", if_valid, 1'b0);
        cyc(1'b0, 1'b1, 2'b00, 16'h1235, 1'b1);
        chk("wrap_addr", imem_address, 16'h0000);
        chk("wrap_pc", if_pc, 16'hFFFE);
        chk("wrap_npc", if_npc, 16'h0000);
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);
        chk("sel00_addr", imem_address, 16'h0002);
        chk("sel00_pc", if_pc, 16'h0000);
        chkb("sel00_valid", if_valid, 1'b1);

        // Random traffic: latency, stalls, redirects, occasional reset.
        force_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            r_r   = ($urandom_range(0, 399) == 0);
            r_rv  = ($urandom_range(0, 9) == 0);
            r_sel = 2'($urandom);
            r_tgt = ($urandom_range(0, 7) == 0) ? (16'hFFFA + 16'($urandom_range(0, 5)))
                                                : 16'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            cyc(r_r, r_rv, r_sel, r_tgt, r_rdy);
        end
        cyc(1'b0, 1'b0, 2'b00, 16'h0000, 1'b1);

        chkb("liveness", (accepts > 300), 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
